reconf_ctrl: RTL and testbench

Parametrised Avalon-MM master that drives the MAX10 dual-configuration IP through a remote-reconfiguration sequence: select image, poll busy, hold off, trigger. Sits between board-level control (button, CPU GPIO) and an externally instantiated dual_conf core. Compared with the first-generation FSM it adds:
- configurable bus and select widths
- read-latency handling
- a bounded busy poll with timeout/error reporting
- a pre-trigger hold-off
- status outputs

---
 rtl/reconf_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_reconf_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reconf_ctrl.sv
// ---------------------------------------------------------------------------
// reconf_ctrl
//
// Avalon-MM master that walks the MAX10 dual-configuration core through a
// remote reconfiguration: write the image select, poll the busy flag until it
// clears (bounded), wait a hold-off, then write the trigger register.
//
// Optional build macro: RECONF_ABORT_EN adds the i_abort input, which cancels
// an in-flight sequence (SEL_WR..HOLD) into ERR with o_err = 2.
//
// Ports:
//   i_clk            system clock
//   i_rstn           asynchronous active-low reset
//   i_reconf_req     reconfiguration request (async level, rising edge starts)
//   i_conf_sel       image select, captured when a request is accepted
//   i_abort          (RECONF_ABORT_EN only) synchronous abort
//   o_avm_address    Avalon address to dual_conf
//   o_avm_read       Avalon read strobe
//   o_avm_write      Avalon write strobe
//   o_avm_writedata  Avalon write data
//   i_avm_readdata   Avalon read data (bit 0 = busy)
//   o_busy           sequence in progress (any state but IDLE/ERR)
//   o_err            0 none, 1 busy-poll timeout, 2 abort
//   o_sel_latched    image select in use
// ---------------------------------------------------------------------------
module reconf_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 1,
    parameter int RD_LAT   = 1,
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4,
    parameter int HOLDOFF  = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_reconf_req,
    input  logic [SEL_W-1:0]  i_conf_sel,
`ifdef RECONF_ABORT_EN
    input  logic              i_abort,
`endif
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    output logic              o_avm_write,
    output logic [DATA_W-1:0] o_avm_writedata,
    input  logic [DATA_W-1:0] i_avm_readdata,
    output logic              o_busy,
    output logic [1:0]        o_err,
    output logic [SEL_W-1:0]  o_sel_latched
);

    localparam int PC_W    = $clog2(POLL_MAX + 1);
    localparam int DLY_MX1 = (RD_LAT > POLL_GAP) ? RD_LAT : POLL_GAP;
    localparam int DLY_MAX = (DLY_MX1 > HOLDOFF) ? DLY_MX1 : HOLDOFF;
    // The delay counter only ever counts 0..DLY_MAX-1.
    localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);

    localparam logic [ADDR_W-1:0] ADDR_TRIG = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_SEL  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_STAT = ADDR_W'(2);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEL_WR,
        S_POLL_RD,
        S_POLL_WAIT,
        S_POLL_IDLE,
        S_HOLD,
        S_TRIG,
        S_WAIT_RCFG,
        S_ERR
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   poll_cnt;
    logic [DLY_W-1:0]  dly_cnt;

    logic req_p0, req_p1, req_p2, req_pulse;
    logic abort_now;
    logic abortable;

    // Only the busy flag is meaningful in the status word.
    logic unused_rdata;
    assign unused_rdata = ^i_avm_readdata[DATA_W-1:1];

`ifdef RECONF_ABORT_EN
    assign abort_now = i_abort;
`else
    assign abort_now = 1'b0;
`endif

    assign abortable = (state == S_SEL_WR)  || (state == S_POLL_RD) ||
                       (state == S_POLL_WAIT) || (state == S_POLL_IDLE) ||
                       (state == S_HOLD);

    // ---- request synchroniser (p0/p1 metastability, p2 edge detect) ----
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            req_p0    <= 1'b0;
            req_p1    <= 1'b0;
            req_p2    <= 1'b0;
            req_pulse <= 1'b0;
        end else begin
            req_p0    <= i_reconf_req;
            req_p1    <= req_p0;
            req_p2    <= req_p1;
            req_pulse <= req_p1 & ~req_p2;
        end
    end

    // ---- sequencer: all Avalon and status outputs are registered here ----
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state           <= S_IDLE;
            o_avm_address   <= '0;
            o_avm_read      <= 1'b0;
            o_avm_write     <= 1'b0;
            o_avm_writedata <= '0;
            o_busy          <= 1'b0;
            o_err           <= ERR_NONE;
            o_sel_latched   <= '0;
            poll_cnt        <= '0;
            dly_cnt         <= '0;
        end else if (abort_now && abortable) begin
            // Abort wins over every other transition, including timeout.
            state       <= S_ERR;
            o_avm_read  <= 1'b0;
            o_avm_write <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= ERR_ABORT;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (req_pulse) begin
                        state           <= S_SEL_WR;
                        o_avm_address   <= ADDR_SEL;
                        o_avm_writedata <= DATA_W'({i_conf_sel, 1'b1});
                        o_avm_write     <= 1'b1;
                        o_busy          <= 1'b1;
                        o_err           <= ERR_NONE;
                        o_sel_latched   <= i_conf_sel;
                        poll_cnt        <= '0;
                    end
                end

                S_SEL_WR: begin
                    state         <= S_POLL_RD;
                    o_avm_write   <= 1'b0;
                    o_avm_read    <= 1'b1;
                    o_avm_address <= ADDR_STAT;
                    poll_cnt      <= poll_cnt + 1'b1;
                end

                S_POLL_RD: begin
                    state      <= S_POLL_WAIT;
                    o_avm_read <= 1'b0;
                    dly_cnt    <= '0;
                end

                S_POLL_WAIT: begin
                    // Readdata is valid RD_LAT cycles after the read strobe,
                    // i.e. in the last cycle of this wait.
                    if (dly_cnt == DLY_W'(RD_LAT - 1)) begin
                        dly_cnt <= '0;
                        if (!i_avm_readdata[0]) begin
                            if (HOLDOFF == 0) begin
                                state           <= S_TRIG;
                                o_avm_address   <= ADDR_TRIG;
                                o_avm_writedata <= DATA_W'(1);
                                o_avm_write     <= 1'b1;
                            end else begin
                                state <= S_HOLD;
                            end
                        end else if (poll_cnt == PC_W'(POLL_MAX)) begin
                            state  <= S_ERR;
                            o_busy <= 1'b0;
                            o_err  <= ERR_TIMEOUT;
                        end else if (POLL_GAP == 0) begin
                            state         <= S_POLL_RD;
                            o_avm_address <= ADDR_STAT;
                            o_avm_read    <= 1'b1;
                            poll_cnt      <= poll_cnt + 1'b1;
                        end else begin
                            state <= S_POLL_IDLE;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                S_POLL_IDLE: begin
                    if (dly_cnt == DLY_W'(POLL_GAP - 1)) begin
                        dly_cnt       <= '0;
                        state         <= S_POLL_RD;
                        o_avm_address <= ADDR_STAT;
                        o_avm_read    <= 1'b1;
                        poll_cnt      <= poll_cnt + 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (dly_cnt == DLY_W'(HOLDOFF - 1)) begin
                        dly_cnt         <= '0;
                        state           <= S_TRIG;
                        o_avm_address   <= ADDR_TRIG;
                        o_avm_writedata <= DATA_W'(1);
                        o_avm_write     <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end

                S_TRIG: begin
                    state       <= S_WAIT_RCFG;
                    o_avm_write <= 1'b0;
                end

                // The device reconfigures from here; only reset leaves.
                S_WAIT_RCFG: begin
                    state <= S_WAIT_RCFG;
                end

                default: begin
                    state       <= S_IDLE;
                    o_avm_read  <= 1'b0;
                    o_avm_write <= 1'b0;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reconf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reconf_ctrl
//
// Directed bench for reconf_ctrl with a small Avalon slave model: the status
// word is valid only exactly RD_LAT cycles after a read strobe and reads busy
// (bit 0 = 1) at every other time. Write and read strobes are logged with
// their cycle numbers so spacing and latency can be checked.
// ---------------------------------------------------------------------------
module tb_reconf_ctrl;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int SEL_W    = 1;
    localparam int RD_LAT   = 3;
    localparam int POLL_MAX = 4;
    localparam int POLL_GAP = 2;
    localparam int HOLDOFF  = 5;
    localparam int SPACING  = 1 + RD_LAT + POLL_GAP;

    logic              clk  = 1'b0;
    logic              rstn = 1'b0;
    logic              req  = 1'b0;
    logic [SEL_W-1:0]  sel  = '0;
`ifdef RECONF_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic [ADDR_W-1:0] addr;
    logic              rd, wr;
    logic [DATA_W-1:0] wdata, rdata;
    logic              busy;
    logic [1:0]        err;
    logic [SEL_W-1:0]  sel_l;

    always #5 clk = ~clk;

    reconf_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .RD_LAT(RD_LAT),
        .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP), .HOLDOFF(HOLDOFF)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_reconf_req   (req),
        .i_conf_sel     (sel),
`ifdef RECONF_ABORT_EN
        .i_abort        (abort),
`endif
        .o_avm_address  (addr),
        .o_avm_read     (rd),
        .o_avm_write    (wr),
        .o_avm_writedata(wdata),
        .i_avm_readdata (rdata),
        .o_busy         (busy),
        .o_err          (err),
        .o_sel_latched  (sel_l)
    );

    // cycle number = number of rising edges so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave response table for the current test
    logic resp [8];
    int   nresp     = 0;
    int   rsp_start = 0;

    // strobe logs
    int                wr_cnt   = 0;
    int                rd_cnt   = 0;
    int                both_cnt = 0;
    int                wr_cyc  [64];
    logic [ADDR_W-1:0] wr_addr [64];
    logic [DATA_W-1:0] wr_data [64];
    int                rd_cyc  [64];
    int                rd_at    = -100;
    logic              rd_resp  = 1'b1;

    always @(negedge clk) begin
        if (wr) begin
            if (wr_cnt < 64) begin
                wr_cyc[wr_cnt]  <= cyc;
                wr_addr[wr_cnt] <= addr;
                wr_data[wr_cnt] <= wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (rd) begin
            if (rd_cnt < 64) rd_cyc[rd_cnt] <= cyc;
            rd_cnt  <= rd_cnt + 1;
            rd_at   <= cyc + RD_LAT;
            rd_resp <= ((rd_cnt - rsp_start) < nresp) ? resp[(rd_cnt - rsp_start) & 7] : 1'b1;
        end
        if (rd && wr) both_cnt <= both_cnt + 1;
    end

    assign rdata = (cyc == rd_at) ? {31'h2AD5_6F00, rd_resp} : 32'hFFFF_FFFF;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_wr(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (wr_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (wr_cnt < n) chk(tag, wr_cnt, n);
    endtask

    task automatic wait_rd(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rd_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rd_cnt < n) chk(tag, rd_cnt, n);
    endtask

    task automatic req_edge(input logic [SEL_W-1:0] s, output int at);
        req = 1'b0;
        repeat (4) @(negedge clk);
        sel = s;
        req = 1'b1;
        at  = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req  = 1'b0;
`ifdef RECONF_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_req, wb, rb, wb2, rb2, k;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", rd, 0);
        chk("rst_wr", wr, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_sel", sel_l, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // normal sequence: sel=1, busy reads 1,1,0
        rsp_start = rd_cnt; nresp = 3;
        resp[0] = 1'b1; resp[1] = 1'b1; resp[2] = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        req_edge(1'b1, t_req);
        wait_wr(wb + 2, 200, "nrm_tmo");
        repeat (20) @(negedge clk);
        chk("nrm_wr_cnt", wr_cnt - wb, 2);
        chk("nrm_rd_cnt", rd_cnt - rb, 3);
        chk("nrm_req_lat", wr_cyc[wb] - t_req, 4);
        chk("nrm_sel_addr", wr_addr[wb], 1);
        chk("nrm_sel_data", wr_data[wb], 3);
        chk("nrm_first_rd", rd_cyc[rb] - wr_cyc[wb], 1);
        chk("nrm_gap1", rd_cyc[rb+1] - rd_cyc[rb], SPACING);
        chk("nrm_gap2", rd_cyc[rb+2] - rd_cyc[rb+1], SPACING);
        chk("nrm_hold", wr_cyc[wb+1] - rd_cyc[rb+2], RD_LAT + HOLDOFF + 1);
        chk("nrm_trig_addr", wr_addr[wb+1], 0);
        chk("nrm_trig_data", wr_data[wb+1], 1);
        chk("nrm_busy", busy, 1);
        chk("nrm_err", err, 0);
        chk("nrm_sel_l", sel_l, 1);

        // reset in the middle of POLL_WAIT
        do_reset();
        rsp_start = rd_cnt; nresp = 0;
        rb = rd_cnt;
        req_edge(1'b1, t_req);
        wait_rd(rb + 1, 100, "mid_tmo");
        #2 rstn = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_rd", rd, 0);
        chk("mid_wr", wr, 0);
        chk("mid_addr", addr, 0);
        chk("mid_wdata", wdata, 0);
        chk("mid_err", err, 0);
        chk("mid_sel_l", sel_l, 0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        wb2 = wr_cnt; rb2 = rd_cnt;
        repeat (30) @(negedge clk);
        chk("mid_no_rd", rd_cnt - rb2, 0);
        chk("mid_no_wr", wr_cnt - wb2, 0);
        chk("mid_idle_busy", busy, 0);

        // busy stuck high: timeout after POLL_MAX reads
        rsp_start = rd_cnt; nresp = 0;
        wb = wr_cnt; rb = rd_cnt;
        req_edge(1'b1, t_req);
        k = 0;
        while (err == 2'd0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        chk("tmo_rd_cnt", rd_cnt - rb, POLL_MAX);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_wr_cnt", wr_cnt - wb, 1);
        chk("tmo_gap", rd_cyc[rb+3] - rd_cyc[rb+2], SPACING);

        // restart from ERR; single poll answered only at exactly RD_LAT
        rsp_start = rd_cnt; nresp = 1; resp[0] = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        req_edge(1'b0, t_req);
        wait_wr(wb + 1, 100, "rst_sel_tmo");
        @(negedge clk);
        chk("re_err_clr", err, 0);
        chk("re_busy", busy, 1);
        chk("re_sel_addr", wr_addr[wb], 1);
        chk("re_sel_data", wr_data[wb], 1);
        wait_wr(wb + 2, 100, "re_trig_tmo");
        repeat (5) @(negedge clk);
        chk("lat_rd_cnt", rd_cnt - rb, 1);
        chk("lat_trig_addr", wr_addr[wb+1], 0);
        chk("lat_hold", wr_cyc[wb+1] - rd_cyc[rb], RD_LAT + HOLDOFF + 1);
        chk("re_sel_l", sel_l, 0);

        // request spam while polling
        do_reset();
        rsp_start = rd_cnt; nresp = 4;
        resp[0] = 1'b1; resp[1] = 1'b1; resp[2] = 1'b1; resp[3] = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        req_edge(1'b1, t_req);
        wait_wr(wb + 1, 100, "spam_tmo");
        for (int i = 0; i < 4; i++) begin
            repeat (3) @(negedge clk);
            req = 1'b0;
            sel = 1'b0;
            repeat (3) @(negedge clk);
            req = 1'b1;
        end
        wait_wr(wb + 2, 200, "spam_trig_tmo");
        repeat (10) @(negedge clk);
        chk("spam_wr_cnt", wr_cnt - wb, 2);
        chk("spam_rd_cnt", rd_cnt - rb, 4);
        chk("spam_trig_addr", wr_addr[wb+1], 0);
        chk("spam_sel_l", sel_l, 1);
        chk("spam_busy", busy, 1);

`ifdef RECONF_ABORT_EN
        // abort during HOLD
        do_reset();
        rsp_start = rd_cnt; nresp = 1; resp[0] = 1'b0;
        wb = wr_cnt; rb = rd_cnt;
        req_edge(1'b1, t_req);
        wait_rd(rb + 1, 100, "ab_tmo");
        k = 0;
        while (cyc < rd_cyc[rb] + 5 && k < 50) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        chk("ab_err", err, 2);
        chk("ab_busy", busy, 0);
        chk("ab_wr_cnt", wr_cnt - wb, 1);

        // abort in WAIT_RCFG is ignored
        rsp_start = rd_cnt; nresp = 1; resp[0] = 1'b0;
        wb = wr_cnt;
        req_edge(1'b0, t_req);
        wait_wr(wb + 2, 200, "ab_trig_tmo");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("ab_ign_err", err, 0);
        chk("ab_ign_busy", busy, 1);
        chk("ab_ign_wr", wr_cnt - wb, 2);
`endif

        chk("rd_wr_overlap", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
